// File: rtl/line_window_if.sv
// rtl/line_window_if.sv - pixel stream in / KxK window stream out bundle
interface line_window_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 3
);
  logic [DATA_WIDTH-1:0]                         pixel_in;
  logic                                          pixel_valid;
  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window_out;
  logic                                          window_valid;
  logic                                          frame_done;

  modport master (
    output pixel_in, pixel_valid,
    input  window_out, window_valid, frame_done
  );

  modport slave (
    input  pixel_in, pixel_valid,
    output window_out, window_valid, frame_done
  );
endinterface

// File: rtl/line_window.sv
// rtl/line_window.sv - KxK sliding window generator over a raster pixel stream
module line_window #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28
) (
  input logic          clk,
  input logic          rst_n,
  line_window_if.slave win_if
);
  localparam int K  = KERNEL_SIZE;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DATA_WIDTH-1:0] line_buf [K-1][IMG_WIDTH];
  logic [DATA_WIDTH-1:0] new_col  [K];
  logic [DATA_WIDTH-1:0] win      [K][K];
  logic [K*K*DATA_WIDTH-1:0] win_flat;
  logic accept, col_last, row_last, win_ready;
  logic window_valid_q, frame_done_q;

  assign accept    = win_if.pixel_valid;
  assign col_last  = (col == CW'(IMG_WIDTH - 1));
  assign row_last  = (row == RW'(IMG_HEIGHT - 1));
  assign win_ready = (row >= RW'(K - 1)) && (col >= CW'(K - 1));

  // Incoming image column: oldest stored row on top, live pixel at the bottom.
  always_comb begin
    for (int i = 0; i < K - 1; i++) begin
      new_col[i] = line_buf[i][col];
    end
    new_col[K-1] = win_if.pixel_in;
  end

  // Line buffers carry no reset; a window is only flagged once every row it
  // covers has been rewritten in the current frame.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < K - 1; i++) begin
        line_buf[i][col] <= new_col[i+1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col            <= '0;
      row            <= '0;
      window_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          win[i][j] <= '0;
        end
      end
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      window_valid_q <= win_ready;
      frame_done_q   <= col_last && row_last;
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) begin
          win[i][j] <= win[i][j+1];
        end
        win[i][K-1] <= new_col[i];
      end
    end else begin
      window_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
    end
  end

  // Element (0,0) lands in the most significant slot.
  always_comb begin
    win_flat = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        win_flat[(K*K-(i*K+j))*DATA_WIDTH-1 -: DATA_WIDTH] = win[i][j];
      end
    end
  end

  assign win_if.window_out   = win_flat;
  assign win_if.window_valid = window_valid_q;
  assign win_if.frame_done   = frame_done_q;
endmodule
